p405s_pdp_skid_stage: RTL
=========================

// Module: p405s_pdp_skid_stage
// PURPOSE
//  Two-entry valid/ready skid stage for a PDP datapath. It accepts words from
//  the upstream producer and holds them in two data slots. It presents the
//  oldest word to the downstream consumer. Upstream ready depends only on
//  registered state, so the stage breaks the ready timing path and still
//  sustains one word per cycle.
// PARAMETERS
//  N        10  data width, bits [0:N-1] (big-endian numbering, bit 0 = MSB)
// PORTS
//  CB        in   1   clock; all state updates on posedge CB
//  RST       in   1   reset; asynchronous, active-high
//  IN_VLD    in   1   upstream word valid
//  IN_RDY    out  1   stage can accept a word this cycle
//  IN_D      in   N   upstream data [0:N-1]
//  FLUSH     in   1   synchronous discard of all held words
//  OUT_VLD   out  1   OUT_D holds a valid word
//  OUT_RDY   in   1   downstream accepts OUT_D this cycle
//  OUT_D     out  N   oldest held word [0:N-1]
//  CNT       out  2   occupancy, 0..2
// BEHAVIOUR
//  - push = IN_VLD & IN_RDY; pop = OUT_VLD & OUT_RDY (both sampled at posedge CB).
//  - IN_RDY  = (CNT != 2) & ~RST. OUT_VLD = (CNT != 0). Both derive from
//    registered state only; there is no combinational path from IN_* or OUT_RDY.
//  - Storage: slot[0], slot[1], 1-bit wr_ptr and rd_ptr, 2-bit count.
//    push writes slot[wr_ptr] and toggles wr_ptr. pop toggles rd_ptr.
//  - OUT_D = slot[rd_ptr]. It is X or stale when OUT_VLD=0; the consumer must
//    not sample it.
//  - Latency: a word pushed into an empty stage drives OUT_VLD=1 in the next cycle.
//  - Count transitions:
//      EMPTY(0): push -> ONE; a pop is impossible.
//      ONE(1):   push only -> FULL; pop only -> EMPTY; push+pop -> ONE
//                (the new word becomes head next cycle).
//      FULL(2):  pop -> ONE; push is blocked because IN_RDY=0.
//  - Back-to-back streaming with OUT_RDY held at 1 stays in ONE at 1 word/cycle.
//  - FLUSH=1: next state is count=0, wr_ptr=rd_ptr=0. FLUSH overrides a
//    coincident push/pop, and the word offered that cycle is dropped.
//    IN_RDY=1 in the next cycle.
//  - RST=1 (asynchronous, at any time, including mid-stream):
//      count=0, ptrs=0, OUT_VLD=0, CNT=0, IN_RDY=0 while RST is asserted.
//      Slot data is not reset.
//    First push is possible in the first cycle after RST deasserts.
//  - X on IN_VLD, OUT_RDY or FLUSH makes control state X in simulation;
//    no X-masking is done.
//  - Ordering is strict FIFO. No word is dropped except by FLUSH or RST;
//    no word is duplicated.
// STRUCTURE
//  - Shared package: the occupancy constants CNT_EMPTY=2'd0, CNT_ONE=2'd1 and
//    CNT_FULL=2'd2. No other typedefs are needed.
//  - Data slots are two instances of the team's enabled-register primitive
//    p405s_PDP_P1EUL2 (N=N):
//      CB=CB, D=IN_D, E1 = push & (wr_ptr==k) & ~FLUSH, L2 = slot[k].
//    Slots are unreset, as that primitive is.
//  - Control (count, pointers, ready/valid) lives in this module with the
//    async RST. The output mux selects between the slots on rd_ptr.
// TESTING
//  1. Reset mid-stream: CNT=2, assert RST between edges ->
//     OUT_VLD=0, CNT=0, IN_RDY=0 immediately; after release, IN_RDY=1.
//  2. Fill: OUT_RDY=0, push 10'h155 then 10'h2AA ->
//     CNT=1, then CNT=2 with IN_RDY=0; OUT_D=10'h155.
//     A third IN_VLD=1 word is not accepted.
//  3. Drain: from test 2, OUT_RDY=1 for 2 cycles ->
//     OUT_D=10'h155 then 10'h2AA; then OUT_VLD=0, CNT=0.
//  4. Streaming: IN_VLD=OUT_RDY=1 with IN_D=0,1,2,...,31 ->
//     OUT_D=0..31 one cycle later, 1 word/cycle, CNT stays 1,
//     IN_RDY never drops.
//  5. Simultaneous push+pop in ONE: head 10'h001, push 10'h002 while popping ->
//     next cycle OUT_D=10'h002, CNT=1.
//  6. FLUSH with CNT=2 and IN_VLD=1 (IN_D=10'h3FF) ->
//     next cycle CNT=0, OUT_VLD=0, IN_RDY=1; 10'h3FF never appears on OUT_D.

Source files
------------

// File: rtl/p405s_pdp_skid_stage_pkg.sv
// Shared constants for the PDP two-entry skid stage.
package p405s_pdp_skid_stage_pkg;
   localparam logic [1:0] CNT_EMPTY = 2'd0;
   localparam logic [1:0] CNT_ONE   = 2'd1;
   localparam logic [1:0] CNT_FULL  = 2'd2;
endpackage

// File: rtl/p405s_PDP_P1EUL2.sv
// Enabled N-bit register primitive: L2 captures D on posedge CB when E1=1.
// No reset; contents are undefined until first written.
module p405s_PDP_P1EUL2 #(
   parameter int N = 10
) (
   input  logic         CB,
   input  logic [0:N-1] D,
   input  logic         E1,
   output logic [0:N-1] L2
);
   logic [0:N-1] l2_d, l2_q;

   always_comb begin
      l2_d = l2_q;
      if (E1) l2_d = D;
   end

   always_ff @(posedge CB) begin
      l2_q <= l2_d;
   end

   assign L2 = l2_q;
endmodule

// File: rtl/p405s_pdp_skid_stage.sv
// Two-entry valid/ready skid stage; ready/valid come only from registered
// occupancy so the upstream ready path is cut while sustaining 1 word/cycle.
module p405s_pdp_skid_stage
   import p405s_pdp_skid_stage_pkg::*;
#(
   parameter int N = 10
) (
   input  logic         CB,
   input  logic         RST,
   input  logic         IN_VLD,
   output logic         IN_RDY,
   input  logic [0:N-1] IN_D,
   input  logic         FLUSH,
   output logic         OUT_VLD,
   input  logic         OUT_RDY,
   output logic [0:N-1] OUT_D,
   output logic [1:0]   CNT
);
   logic [1:0]         cnt_d, cnt_q;
   logic               wr_ptr_d, wr_ptr_q;
   logic               rd_ptr_d, rd_ptr_q;
   logic               push, pop;
   logic [1:0]         slot_we;
   logic [1:0][0:N-1]  slot_l2;

   assign IN_RDY  = (cnt_q != CNT_FULL) & ~RST;
   assign OUT_VLD = (cnt_q != CNT_EMPTY);
   assign CNT     = cnt_q;
   assign push    = IN_VLD & IN_RDY;
   assign pop     = OUT_VLD & OUT_RDY;

   always_comb begin
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (FLUSH) begin
         cnt_d    = CNT_EMPTY;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         case (cnt_q)
            CNT_EMPTY: if (push) cnt_d = CNT_ONE;
            CNT_ONE: begin
               if (push & ~pop)      cnt_d = CNT_FULL;
               else if (pop & ~push) cnt_d = CNT_EMPTY;
            end
            CNT_FULL:  if (pop) cnt_d = CNT_ONE;
            default:   cnt_d = CNT_EMPTY;
         endcase
      end
   end

   always_ff @(posedge CB or posedge RST) begin
      if (RST) begin
         cnt_q    <= CNT_EMPTY;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // A flushed push must not land in a slot even though it never becomes visible.
   for (genvar k = 0; k < 2; k++) begin : g_slot
      assign slot_we[k] = push & (wr_ptr_q == k[0]) & ~FLUSH;
      p405s_PDP_P1EUL2 #(.N(N)) u_slot (
         .CB (CB),
         .D  (IN_D),
         .E1 (slot_we[k]),
         .L2 (slot_l2[k])
      );
   end

   assign OUT_D = slot_l2[rd_ptr_q];
endmodule
